// File: rtl/riscv_pkg.sv
// Shared core types: register width, immediate packing formats, and the
// encoder's error codes and FSM states.
package riscv_pkg;

  localparam int XLEN = 32;

  // Immediate layout selector. Encodings 5..7 are unused and are rejected
  // as a bad type by the encoder.
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } immediate_type_e;

  // Encoder check result; the numeric values double as the err_code output.
  typedef enum logic [1:0] {
    ENC_OK       = 2'd0,
    ENC_RANGE    = 2'd1,
    ENC_MISALIGN = 2'd2,
    ENC_BADTYPE  = 2'd3
  } enc_err_e;

  // Instruction writer FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    WR   = 2'd2,
    ERR  = 2'd3
  } enc_state_e;

endpackage

// File: rtl/imm_pack_unit.sv
// Combinational immediate packer: places a value-form immediate into its
// I/S/B/U/J bit positions around the register/opcode fields and reports
// whether the immediate is representable in that format.
module imm_pack_unit
  import riscv_pkg::*;
(
  input  immediate_type_e  imm_type_i,
  input  logic [6:0]       opcode_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  imm_i,
  output logic [31:0]      word_o,
  output enc_err_e         err_o
);

  // A value fits an N+1 bit signed field when every bit above bit N
  // matches bit N (i.e. it equals its own sign extension from bit N).
  logic fits_12b;
  logic fits_13b;
  logic fits_21b;

  assign fits_12b = (&imm_i[XLEN-1:11]) | ~(|imm_i[XLEN-1:11]);
  assign fits_13b = (&imm_i[XLEN-1:12]) | ~(|imm_i[XLEN-1:12]);
  assign fits_21b = (&imm_i[XLEN-1:20]) | ~(|imm_i[XLEN-1:20]);

  // Pack by format; precedence is bad type, then misalignment, then range.
  always_comb begin
    word_o = '0;
    err_o  = ENC_OK;
    case (imm_type_i)
      IMM_I: begin
        word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        if (!fits_12b) err_o = ENC_RANGE;
      end
      IMM_S: begin
        word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        if (!fits_12b) err_o = ENC_RANGE;
      end
      IMM_B: begin
        word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                  imm_i[4:1], imm_i[11], opcode_i};
        if (imm_i[0])       err_o = ENC_MISALIGN;
        else if (!fits_13b) err_o = ENC_RANGE;
      end
      IMM_U: begin
        word_o = {imm_i[31:12], rd_i, opcode_i};
        if (|imm_i[11:0]) err_o = ENC_RANGE;
      end
      IMM_J: begin
        word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        if (imm_i[0])       err_o = ENC_MISALIGN;
        else if (!fits_21b) err_o = ENC_RANGE;
      end
      default: begin
        err_o = ENC_BADTYPE;
      end
    endcase
  end

endmodule

// File: rtl/instr_encode_writer.sv
// Program-load instruction assembler: accepts instruction fields over a
// valid/ready handshake, encodes and checks them, and writes each accepted
// word into IMEM at an auto-incrementing address.
//
// Handshake: a request is taken on a rising clk edge where req_valid and
// req_ready are both 1. req_ready is only high in IDLE, when IMEM is not
// full and restart is low; fields are latched on that edge and the
// requester may change them afterwards.
module instr_encode_writer
  import riscv_pkg::*;
#(
  parameter int              IMEM_DEPTH = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  immediate_type_e               req_imm_type,
  input  logic [6:0]                    req_opcode,
  input  logic [4:0]                    req_rd,
  input  logic [4:0]                    req_rs1,
  input  logic [4:0]                    req_rs2,
  input  logic [2:0]                    req_funct3,
  input  logic [XLEN-1:0]               req_imm,
  input  logic                          restart,
  output logic                          imem_we,
  output logic [XLEN-1:0]               imem_addr,
  output logic [XLEN-1:0]               imem_wdata,
  output logic                          err_valid,
  output logic [1:0]                    err_code,
  output logic [15:0]                   err_count,
  output logic [$clog2(IMEM_DEPTH):0]   word_count,
  output logic                          full,
  output enc_state_e                    dbg_state
);

  localparam int CW = $clog2(IMEM_DEPTH) + 1;

  enc_state_e      state_q, state_d;
  immediate_type_e type_q;
  logic [6:0]      opcode_q;
  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] wdata_q, addr_q;
  enc_err_e        err_code_q;
  logic [15:0]     err_cnt_q, err_cnt_d;
  // The write pointer and the word count always move together, so a single
  // counter serves as both.
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            accept;
  logic [31:0]     pack_word;
  enc_err_e        pack_err;
  logic [CW-1:0]   ptr_eff;
  logic [XLEN-1:0] ptr_byte;

  imm_pack_unit u_pack (
    .imm_type_i (type_q),
    .opcode_i   (opcode_q),
    .rd_i       (rd_q),
    .rs1_i      (rs1_q),
    .rs2_i      (rs2_q),
    .funct3_i   (funct3_q),
    .imm_i      (imm_q),
    .word_o     (pack_word),
    .err_o      (pack_err)
  );

  assign full      = (cnt_q == CW'(IMEM_DEPTH));
  assign req_ready = (state_q == IDLE) && !full && !restart;
  assign accept    = req_valid && req_ready;

  // A restart coinciding with ENC retargets the upcoming write to word 0.
  assign ptr_eff  = restart ? '0 : cnt_q;
  assign ptr_byte = XLEN'({ptr_eff, 2'b00});

  // Next-state and one-cycle strobes of the IDLE/ENC/WR/ERR sequencer.
  always_comb begin
    state_d   = state_q;
    imem_we   = 1'b0;
    err_valid = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = ENC;
      ENC:  state_d = (pack_err == ENC_OK) ? WR : ERR;
      WR: begin
        imem_we = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter next values; restart overrides the post-write increment.
  always_comb begin
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    if (restart)            cnt_d = '0;
    else if (state_q == WR) cnt_d = cnt_q + 1'b1;
    if (state_q == ERR && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture request fields on the handshake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q   <= IMM_I;
      opcode_q <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      funct3_q <= '0;
      imm_q    <= '0;
    end else if (accept) begin
      type_q   <= req_imm_type;
      opcode_q <= req_opcode;
      rd_q     <= req_rd;
      rs1_q    <= req_rs1;
      rs2_q    <= req_rs2;
      funct3_q <= req_funct3;
      imm_q    <= req_imm;
    end
  end

  // Register the encoded word, its address and the check result out of ENC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata_q    <= '0;
      addr_q     <= BASE_ADDR;
      err_code_q <= ENC_OK;
    end else if (state_q == ENC) begin
      if (pack_err == ENC_OK) begin
        wdata_q    <= pack_word;
        addr_q     <= BASE_ADDR + ptr_byte;
        err_code_q <= ENC_OK;
      end else begin
        err_code_q <= pack_err;
      end
    end
  end

  // Word and rejection counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign err_code   = err_code_q;
  assign err_count  = err_cnt_q;
  assign word_count = cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_instr_encode_writer.sv
// Bench for instr_encode_writer: directed cases followed by a randomized
// sweep checked against an immediate-decoding reference model.
module tb_instr_encode_writer;
  import riscv_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic            clk, rst_n;
  logic            req_valid, req_ready;
  immediate_type_e req_imm_type;
  logic [6:0]      req_opcode;
  logic [4:0]      req_rd, req_rs1, req_rs2;
  logic [2:0]      req_funct3;
  logic [31:0]     req_imm;
  logic            restart;
  logic            imem_we;
  logic [31:0]     imem_addr, imem_wdata;
  logic            err_valid;
  logic [1:0]      err_code;
  logic [15:0]     err_count;
  logic [2:0]      word_count;
  logic            full;
  enc_state_e      dbg_state;

  int total;
  int passed;
  int fails;

  // Reference model state.
  int          m_ptr;
  int          m_errs;
  logic [1:0]  m_code;
  logic [31:0] m_last_addr;

  instr_encode_writer #(.IMEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_imm_type (req_imm_type),
    .req_opcode   (req_opcode),
    .req_rd       (req_rd),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_funct3   (req_funct3),
    .req_imm      (req_imm),
    .restart      (restart),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .err_valid    (err_valid),
    .err_code     (err_code),
    .err_count    (err_count),
    .word_count   (word_count),
    .full         (full),
    .dbg_state    (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Core-side immediate extraction: recovers the value an instruction word carries.
  function automatic logic [31:0] decode_imm(input immediate_type_e t, input logic [31:0] w);
    case (t)
      IMM_I:   return {{20{w[31]}}, w[31:20]};
      IMM_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
      IMM_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      IMM_U:   return {w[31:12], 12'h000};
      IMM_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  // Expected rejection code from signed numeric ranges.
  function automatic logic [1:0] model_err(input immediate_type_e t, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    if (int'(t) > 4) return 2'd3;
    if ((t == IMM_B || t == IMM_J) && imm[0]) return 2'd2;
    case (t)
      IMM_I, IMM_S: if (s < -2048 || s > 2047) return 2'd1;
      IMM_B:        if (s < -4096 || s > 4095) return 2'd1;
      IMM_J:        if (s < -1048576 || s > 1048575) return 2'd1;
      default:      if (imm[11:0] != 12'h000) return 2'd1;
    endcase
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_ptr       = 0;
    m_errs      = 0;
    m_code      = 2'd0;
    m_last_addr = BASE;
  endtask

  task automatic drive_fields(input immediate_type_e t, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [31:0] imm);
    req_imm_type = t;
    req_opcode   = op;
    req_rd       = rd;
    req_rs1      = rs1;
    req_rs2      = rs2;
    req_funct3   = f3;
    req_imm      = imm;
  endtask

  // Driver: one full request, checked cycle by cycle against the model.
  task automatic do_req(input immediate_type_e t, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [31:0] imm, input logic [31:0] exp_word, input bit chk_word);
    int n;
    logic [1:0] ec;
    @(negedge clk);
    drive_fields(t, op, rd, rs1, rs2, f3, imm);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(req_ready), 32'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("enc_quiet", {imem_we, err_valid}, 2'b00);
    @(negedge clk);
    ec = model_err(t, imm);
    if (ec == 2'd0) begin
      check("we_pulse", {imem_we, err_valid}, 2'b10);
      check("addr", imem_addr, BASE + 32'(4 * m_ptr));
      check("roundtrip", decode_imm(t, imem_wdata), imm);
      check("opcode", imem_wdata[6:0], op);
      if (t != IMM_S && t != IMM_B) check("rd", imem_wdata[11:7], rd);
      if (t == IMM_I || t == IMM_S || t == IMM_B) begin
        check("funct3", imem_wdata[14:12], f3);
        check("rs1", imem_wdata[19:15], rs1);
      end
      if (t == IMM_S || t == IMM_B) check("rs2", imem_wdata[24:20], rs2);
      if (chk_word) check("wdata", imem_wdata, exp_word);
      m_last_addr = BASE + 32'(4 * m_ptr);
      m_ptr++;
      m_code = 2'd0;
    end else begin
      check("err_pulse", {imem_we, err_valid}, 2'b01);
      check("err_code", err_code, ec);
      check("addr_hold", imem_addr, m_last_addr);
      m_code = ec;
      if (m_errs < 65535) m_errs++;
    end
    @(negedge clk);
    check("word_count", word_count, m_ptr);
    check("err_count", err_count, m_errs);
    check("err_code_hold", err_code, m_code);
    check("full", 32'(full), 32'(m_ptr == DEPTH));
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    #1 check("ready_in_restart", 32'(req_ready), 32'd0);
    @(negedge clk);
    restart = 1'b0;
    m_ptr = 0;
    check("restart_count", word_count, 0);
    check("restart_full", 32'(full), 32'd0);
  endtask

  initial begin
    immediate_type_e t;
    logic [31:0] imm;
    int n;
    total = 0; passed = 0; fails = 0;
    rst_n = 1'b0; req_valid = 1'b0; restart = 1'b0;
    drive_fields(IMM_I, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", imem_addr, BASE);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_err", {err_valid, err_code}, 3'b000);
    check("rst_err_count", err_count, 0);
    check("rst_word_count", word_count, 0);
    check("rst_full", 32'(full), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_state", dbg_state, IDLE);

    // Directed encodings and rejections
    do_req(IMM_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b1);
    do_req(IMM_B, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b1);
    do_req(IMM_U, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 32'h1234_52B7, 1'b1);
    do_req(IMM_J, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3, 32'd0, 1'b0);
    do_req(IMM_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800, 32'd0, 1'b0);
    do_req(immediate_type_e'(3'd6), 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd3, 32'd0, 1'b0);
    do_req(IMM_U, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5001, 32'd0, 1'b0);
    do_req(IMM_S, 7'b0100011, 5'd0, 5'd2, 5'd3, 3'd2, 32'h0000_07FF, 32'h7E31_2FA3, 1'b1);

    // Full: a held request is never accepted
    @(negedge clk);
    drive_fields(IMM_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
    req_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("full_ready", 32'(req_ready), 32'd0);
      check("full_no_we", 32'(imem_we), 32'd0);
    end
    check("full_count", word_count, DEPTH);
    req_valid = 1'b0;
    do_restart();

    // restart together with req_valid in IDLE is not an acceptance
    @(negedge clk);
    restart = 1'b1;
    req_valid = 1'b1;
    #1 check("restart_valid_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("restart_valid_state", dbg_state, IDLE);
    restart = 1'b0;
    req_valid = 1'b0;
    do_req(IMM_I, 7'b0010011, 5'd3, 5'd4, 5'd0, 3'd0, 32'd5, 32'h0052_0193, 1'b1);

    // Reset during WR
    @(negedge clk);
    drive_fields(IMM_I, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 32'd7);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("wr_before_reset", 32'(imem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_we", 32'(imem_we), 32'd0);
    check("reset_word_count", word_count, 0);
    check("reset_err_count", err_count, 0);
    check("reset_addr", imem_addr, BASE);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("post_reset_ready", 32'(req_ready), 32'd1);
    do_req(IMM_I, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 32'd7, 32'h0070_0113, 1'b1);

    // Randomized sweep over all types, mostly legal immediates
    for (int i = 0; i < 10000; i++) begin
      if (m_ptr == DEPTH) do_restart();
      n = $urandom_range(0, 19);
      t = (n < 19) ? immediate_type_e'(3'(n % 5)) : immediate_type_e'(3'(5 + $urandom_range(0, 2)));
      if ($urandom_range(0, 9) != 0) begin
        case (t)
          IMM_I, IMM_S: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
          IMM_B:        imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
          IMM_J:        imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
          default:      imm = $urandom & 32'hFFFF_F000;
        endcase
      end else begin
        imm = $urandom;
        if ($urandom_range(0, 1) == 1) imm = imm & 32'h0000_0FFF;
      end
      do_req(t, 7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), imm, 32'd0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
